// File: rtl/spi_pkg.sv
// Shared constants for the SPI burst master: command byte, word width,
// slave test-pattern step and the frame FSM state encodings.
package spi_pkg;

  localparam logic [7:0]  SPI_CMD_READ     = 8'hF0;
  localparam int          SPI_WORD_W       = 16;
  localparam logic [15:0] SPI_PATTERN_STEP = 16'h1111;

  localparam logic [2:0] ST_IDLE  = 3'd0;
  localparam logic [2:0] ST_LEAD  = 3'd1;
  localparam logic [2:0] ST_SHIFT = 3'd2;
  localparam logic [2:0] ST_TRAIL = 3'd3;
  localparam logic [2:0] ST_GAP   = 3'd4;
  localparam logic [2:0] ST_DONE  = 3'd5;

  function automatic logic [SPI_WORD_W-1:0] spi_read_cmd(input logic [4:0] ch);
    return {SPI_CMD_READ, 3'b000, ch};
  endfunction

endpackage

// File: rtl/spi_shift16.sv
// One 16-bit mode-0 SPI frame: SCLK divider, bit counter, TX/RX shifters.
// load primes the TX word (MOSI shows bit 15), go starts clocking.
module spi_shift16
  import spi_pkg::*;
#(
  parameter int CLK_DIV = 8
) (
  input  logic                  i_clk,
  input  logic                  rst,
  input  logic                  load,
  input  logic [SPI_WORD_W-1:0] tx_word,
  input  logic                  go,
  input  logic                  miso,
  output logic                  sclk,
  output logic                  mosi,
  output logic [SPI_WORD_W-1:0] rx_word,
  output logic                  frame_done
);

  localparam int DW = $clog2(CLK_DIV + 1);
  localparam logic [DW-1:0] DIV_LAST = DW'(CLK_DIV - 1);
  localparam logic [4:0]    BIT_LAST = 5'(SPI_WORD_W - 1);

  logic [SPI_WORD_W-1:0] tx_sh;
  logic [DW-1:0]         div_cnt;
  logic [4:0]            bit_cnt;
  logic                  running;

  always_ff @(posedge i_clk or posedge rst) begin
    if (rst) begin
      tx_sh   <= '0;
      rx_word <= '0;
      div_cnt <= '0;
      bit_cnt <= '0;
      running <= 1'b0;
      sclk    <= 1'b0;
      mosi    <= 1'b0;
    end else if (load) begin
      tx_sh   <= tx_word;
      mosi    <= tx_word[SPI_WORD_W-1];
      rx_word <= '0;
      div_cnt <= '0;
      bit_cnt <= '0;
      running <= 1'b0;
      sclk    <= 1'b0;
    end else if (go) begin
      running <= 1'b1;
      div_cnt <= '0;
    end else if (running) begin
      if (div_cnt == DIV_LAST) begin
        div_cnt <= '0;
        if (!sclk) begin
          // Rising edge: capture MISO together with the SCLK transition.
          sclk    <= 1'b1;
          rx_word <= {rx_word[SPI_WORD_W-2:0], miso};
        end else begin
          sclk    <= 1'b0;
          tx_sh   <= {tx_sh[SPI_WORD_W-2:0], 1'b0};
          mosi    <= tx_sh[SPI_WORD_W-2];
          bit_cnt <= bit_cnt + 5'd1;
          if (bit_cnt == BIT_LAST) running <= 1'b0;
        end
      end else begin
        div_cnt <= div_cnt + 1'b1;
      end
    end
  end

  // High in the last SCLK-high cycle of bit 15.
  assign frame_done = running && sclk && (div_cnt == DIV_LAST) && (bit_cnt == BIT_LAST);

endmodule

// File: rtl/spi_burst_master.sv
// SPI mode-0 burst reader: one read command frame, then NUM_WORDS data frames.
// Define SPI_BURST_SEQ_CHECK_EN to enable the +16'h1111 word-sequence checker on o_err.
module spi_burst_master
  import spi_pkg::*;
#(
  parameter int CLK_DIV   = 8,
  parameter int NUM_WORDS = 5,
  parameter int CS_GAP    = 4
) (
  input  logic                  i_clk,
  input  logic                  rst,
  input  logic                  i_start,
  input  logic [4:0]            i_channel,
  output logic                  o_busy,
  output logic                  o_cs,
  output logic                  o_sclk,
  output logic                  o_mosi,
  input  logic                  i_miso,
  output logic [SPI_WORD_W-1:0] o_rd_data,
  output logic                  o_rd_valid,
  output logic                  o_done,
  output logic                  o_err
);

  localparam int CMAX = (CLK_DIV > CS_GAP) ? CLK_DIV : CS_GAP;
  localparam int CW   = $clog2(CMAX + 1);
  localparam logic [CW-1:0] DIV_LAST   = CW'(CLK_DIV - 1);
  localparam logic [CW-1:0] GAP_LAST   = CW'(CS_GAP - 1);
  localparam logic [3:0]    LAST_FRAME = 4'(NUM_WORDS);

  logic [2:0]            state, nstate;
  logic [CW-1:0]         cnt;
  logic [3:0]            frame;
  logic                  load, go, frame_done, capture, accept;
  logic [SPI_WORD_W-1:0] tx_next, rx_word;

  assign accept  = (state == ST_IDLE) && i_start;
  assign capture = (state == ST_TRAIL) && (nstate == ST_GAP) && (frame != 4'd0);

  always_comb begin
    nstate  = state;
    load    = 1'b0;
    go      = 1'b0;
    tx_next = '0;
    case (state)
      ST_IDLE: if (i_start) begin
        nstate  = ST_LEAD;
        load    = 1'b1;
        tx_next = spi_read_cmd(i_channel);
      end
      ST_LEAD: if (cnt == DIV_LAST) begin
        nstate = ST_SHIFT;
        go     = 1'b1;
      end
      ST_SHIFT: if (frame_done) nstate = ST_TRAIL;
      ST_TRAIL: if (cnt == DIV_LAST) nstate = ST_GAP;
      ST_GAP: if (cnt == GAP_LAST) begin
        if (frame == LAST_FRAME) begin
          nstate = ST_DONE;
        end else begin
          // Data frames clock out zeros so the slave never sees a new command.
          nstate = ST_LEAD;
          load   = 1'b1;
        end
      end
      ST_DONE: nstate = ST_IDLE;
      default: nstate = ST_IDLE;
    endcase
  end

  // Strobes and CS are registered from the next state so they stay glitch-free.
  always_ff @(posedge i_clk or posedge rst) begin
    if (rst) begin
      state      <= ST_IDLE;
      cnt        <= '0;
      frame      <= '0;
      o_cs       <= 1'b1;
      o_busy     <= 1'b0;
      o_done     <= 1'b0;
      o_rd_valid <= 1'b0;
      o_rd_data  <= '0;
    end else begin
      state      <= nstate;
      cnt        <= (nstate != state) ? '0 : cnt + 1'b1;
      if (accept)
        frame <= '0;
      else if ((state == ST_GAP) && (nstate == ST_LEAD))
        frame <= frame + 4'd1;
      o_cs       <= !(nstate inside {ST_LEAD, ST_SHIFT, ST_TRAIL});
      o_busy     <= (nstate != ST_IDLE) && (nstate != ST_DONE);
      o_done     <= (nstate == ST_DONE);
      o_rd_valid <= capture;
      if (capture) o_rd_data <= rx_word;
    end
  end

  spi_shift16 #(.CLK_DIV(CLK_DIV)) u_shift (
    .i_clk      (i_clk),
    .rst        (rst),
    .load       (load),
    .tx_word    (tx_next),
    .go         (go),
    .miso       (i_miso),
    .sclk       (o_sclk),
    .mosi       (o_mosi),
    .rx_word    (rx_word),
    .frame_done (frame_done)
  );

`ifdef SPI_BURST_SEQ_CHECK_EN
  // o_rd_data still holds word n-1 when word n is captured.
  always_ff @(posedge i_clk or posedge rst) begin
    if (rst)
      o_err <= 1'b0;
    else if (accept)
      o_err <= 1'b0;
    else if (capture && (frame >= 4'd2) && (rx_word != o_rd_data + SPI_PATTERN_STEP))
      o_err <= 1'b1;
  end
`else
  assign o_err = 1'b0;
`endif

endmodule

// File: doc/spi_burst_master.md
# spi_burst_master

SPI mode-0 master that issues the read command `{8'hF0, 3'b000, channel[4:0]}` to the board's SPI slave controller and reads back a fixed-length burst of 16-bit words. It sits on the host/test side of the SPI link, driving CS, SCLK and MOSI and sampling MISO. Each received word is presented on a valid strobe to local logic.

## Interface
- `CLK_DIV`, 8: i_clk cycles per SCLK half-period; legal range ≥4. The slave's input synchroniser needs ≥4.
- `NUM_WORDS`, 5: data frames read after the command frame; range 1–15.
- `CS_GAP`, 4: i_clk cycles CS is held high between frames; must be ≥2.
- `i_clk`, in, 1: system clock.
- `rst`, in, 1: asynchronous, active-high reset.
- `i_start`, in, 1: one-cycle request; sampled only in IDLE.
- `i_channel`, in, 5: channel number; latched on an accepted start.
- `o_busy`, out, 1: high from the cycle after an accepted start until o_done.
- `o_cs`, out, 1: chip select, active low.
- `o_sclk`, out, 1: SPI clock; idles low.
- `o_mosi`, out, 1: master data out, MSB first.
- `i_miso`, in, 1: slave data in.
- `o_rd_data`, out, 16: last received word.
- `o_rd_valid`, out, 1: one-cycle strobe when o_rd_data updates.
- `o_done`, out, 1: one-cycle strobe at burst end.
- `o_err`, out, 1: sequence-check error flag; tied 0 when the check is compiled out.

## Operation
- Reset values: o_cs=1, o_sclk=0, o_mosi=0, o_busy=0, o_rd_data=0, o_rd_valid=0, o_done=0, o_err=0. The FSM resets to IDLE.
- FSM states: IDLE → LEAD → SHIFT → TRAIL → GAP → back to LEAD (more frames remain) or DONE → IDLE.
- IDLE: when i_start=1, latch i_channel, set frame counter to 0, load the TX word, and go to LEAD.
- TX word: frame 0 sends `{8'hF0, 3'b000, ch}`. Frames 1..NUM_WORDS send 16'h0000, so the slave never restarts.
- LEAD: o_cs=0 and o_mosi=bit15 for CLK_DIV cycles.
- SHIFT: 16 bits.
  - Each bit is CLK_DIV cycles with SCLK low, then CLK_DIV cycles with SCLK high.
  - i_miso is sampled into the RX shift register on the cycle o_sclk rises.
  - o_mosi changes to the next bit on the cycle o_sclk falls.
- TRAIL: SCLK low for CLK_DIV cycles, then o_cs=1.
- GAP: CS_GAP cycles with o_cs=1.
  - On the first GAP cycle of a frame ≥1, copy the RX register to o_rd_data and pulse o_rd_valid. Frame 0's RX data is discarded.
- After frame NUM_WORDS's GAP, go to DONE. DONE pulses o_done for one cycle, clears o_busy, and returns to IDLE.
- i_start is ignored while o_busy=1. A start in the cycle after DONE is accepted.
- Reset mid-burst: all outputs return to their reset values asynchronously. No partial word is output.
- Frame counter is 4 bits; TX/RX shift registers are 16 bits; the bit counter is 5 bits, terminal at 16.

## Timing
- Accepted start → o_cs falls: 1 cycle.
- CS-low window per frame: CLK_DIV + 32·CLK_DIV + CLK_DIV cycles. That is 136 cycles at CLK_DIV=4.
- Frame period: CS-low window + CS_GAP.
- o_rd_valid for frame k falls 1 cycle after o_cs rises for that frame.
- o_done follows the last o_rd_valid by CS_GAP cycles.

## Configuration
- `SPI_BURST_SEQ_CHECK_EN` defined: check that each data word n≥2 equals word n−1 + 16'h1111, mod 2^16. This is the slave's test-pattern step.
  - On a mismatch, o_err is set in the o_rd_valid cycle and stays set until the next accepted start.
  - The burst always completes on a mismatch.
- Macro undefined: no checker logic; o_err is constant 0.

## Structure
- Shared package `spi_pkg` holds:
  - `SPI_CMD_READ` = 8'hF0
  - `SPI_WORD_W` = 16
  - `SPI_PATTERN_STEP` = 16'h1111
  - state encodings IDLE/LEAD/SHIFT/TRAIL/GAP/DONE
- Sub-module `spi_shift16`: SCLK divider, bit counter, and TX/RX shift registers. It takes a load/go handshake and returns a frame-done pulse.
- The top level keeps the frame FSM, command formation, output strobes, and the optional checker.

## Test plan
All scenarios use CLK_DIV=4 and CS_GAP=4.
- **Reset with no start:** all outputs hold their reset values. Then assert rst mid-SHIFT: o_cs=1 and o_sclk=0 in the same cycle.
- **Start with i_channel=5'd3, NUM_WORDS=5:**
  - MOSI frames decode as F003, 0000, 0000, 0000, 0000, 0000.
  - Exactly 6 CS-low windows of 136 cycles each, with 16 rising edges per window.
- **Bench slave returns 89AB, 9ABC, ABCD, BCDE, CDEF:** five o_rd_valid pulses carrying those values in order. Then one o_done pulse, and o_err=0.
- **Macro on, slave returns 89AB, 9ABC, 1234, …:** o_err rises on the third o_rd_valid and stays high through o_done. It clears on the next start.
- **i_start pulsed mid-burst:** ignored; CS timing is unchanged. A start one cycle after o_done begins a new burst.
- **Start with i_channel=5'd31:** first MOSI word is F01F, and bits 7:5 are 0.
